mem_access_unit: RTL and testbench

Initiator-side load/store unit for the byte-addressed data memory (32-bit word, 2^M words, big-endian byte lanes, combinational read, masked synchronous write). It accepts one load or store at a time from the pipeline over a valid/ready handshake, and drives the memory's address, mask, write-flag and write-data port. It extracts and sign- or zero-extends load data, rejects illegal or out-of-range accesses, and returns a response over a second valid/ready handshake.

---
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshakes plus the data-memory port of the load/store unit.
// The unit is the slave; the pipeline and memory together sit on the master side.
interface mem_access_unit_if #(
  parameter int M = 10
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [1:0]     req_size;
  logic           req_unsigned;
  logic [M+1:0]   req_addr;
  logic [31:0]    req_wdata;
  logic           resp_valid;
  logic           resp_ready;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic [M+1:0]   mem_address;
  logic [31:0]    mem_mask;
  logic           mem_wf;
  logic [31:0]    mem_w;
  logic [31:0]    mem_v;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_v,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_mask, mem_wf, mem_w
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_v,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_mask, mem_wf, mem_w
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one access at a time, big-endian byte lanes (lane 0 = bits 31:24),
// range/size checking, load extension, and a held response until consumed.
module mem_access_unit #(
  parameter int M = 10
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);
  localparam int AW = M + 2;

  typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, RESP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     size_q;
  logic           uns_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    w_q;
  logic [31:0]    rdata_q;
  logic           err_q;

  logic [AW:0]    span;
  logic [AW:0]    last_byte;
  logic           illegal;
  logic [31:0]    w_aligned;
  logic [31:0]    load_val;
  logic           write_active;
  logic [3:0]     lane_en;
  logic [31:0]    mask;

  // Last byte touched, one bit wider than the address so overflow flags out-of-range.
  always_comb begin
    span = '0;
    case (bus.req_size)
      2'b00:   span = (AW+1)'(0);
      2'b01:   span = (AW+1)'(1);
      default: span = (AW+1)'(3);
    endcase
    last_byte = {1'b0, bus.req_addr} + span;
    illegal   = (bus.req_size == 2'b11) || last_byte[AW];
  end

  always_comb begin
    w_aligned = bus.req_wdata;
    case (bus.req_size)
      2'b00:   w_aligned = {bus.req_wdata[7:0], 24'h0};
      2'b01:   w_aligned = {bus.req_wdata[15:0], 16'h0};
      default: w_aligned = bus.req_wdata;
    endcase
  end

  always_comb begin
    load_val = bus.mem_v;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & bus.mem_v[31]}}, bus.mem_v[31:24]};
      2'b01:   load_val = {{16{~uns_q & bus.mem_v[31]}}, bus.mem_v[31:16]};
      default: load_val = bus.mem_v;
    endcase
  end

  // A reset arriving during the write cycle must suppress the write immediately.
  assign write_active = (state_q == WRITE) && !rst;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = (size_q == 2'b10) || (gi == 0) || ((gi == 1) && (size_q == 2'b01));
      assign mask[31-8*gi -: 8] = {8{lane_en[gi] & write_active}};
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (illegal)         state_d = ERR;
          else if (bus.req_we) state_d = WRITE;
          else                 state_d = READ;
        end
      end
      READ, WRITE, ERR: state_d = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      w_q     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            size_q <= bus.req_size;
            uns_q  <= bus.req_unsigned;
            // Rejected requests leave the memory port showing the last real access.
            if (!illegal) begin
              addr_q <= bus.req_addr;
              w_q    <= w_aligned;
            end
          end
        end
        READ:  rdata_q <= load_val;
        WRITE: rdata_q <= '0;
        ERR: begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
        RESP: if (bus.resp_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_w       = w_q;
  assign bus.mem_wf      = write_active;
  assign bus.mem_mask    = mask;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model, expected-response queue,
// directed scenarios and a random back-to-back run against a shadow memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   wf_count = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [32:0] exp_q [$];

  logic        acc_wf;
  logic [31:0] acc_mask;
  logic [11:0] acc_addr;
  int          acc_cyc;

  mem_access_unit_if #(.M(10)) bus ();

  mem_access_unit #(.M(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_wf) wf_count <= wf_count + 1;

  assign bus.mem_v = {mem[bus.mem_address], mem[bus.mem_address + 12'd1],
                      mem[bus.mem_address + 12'd2], mem[bus.mem_address + 12'd3]};

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (bus.mem_wf) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_mask[31-8*k]) mem[bus.mem_address + 12'(k)] <= bus.mem_w[31-8*k -: 8];
    end
  end

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [11:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_mem[a];
    b1 = ref_mem[a + 12'd1];
    b2 = ref_mem[a + 12'd2];
    b3 = ref_mem[a + 12'd3];
    case (size)
      2'b00:   return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   return uns ? {16'h0, b0, b1} : {{16{b0[7]}}, b0, b1};
      default: return {b0, b1, b2, b3};
    endcase
  endfunction

  // Issues one request and waits (bounded) for its response; lat = cycles from accept to resp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wd,
                        output logic [32:0] got, output int lat);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    acc_cyc  = cyc;
    acc_wf   = bus.mem_wf;
    acc_mask = bus.mem_mask;
    acc_addr = bus.mem_address;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus.resp_err, bus.resp_rdata};
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err} !== 3'b100) begin
      n_bad++; $display("FAIL reset_hs got=%b exp=100", {bus.req_ready, bus.resp_valid, bus.resp_err});
    end
    n_cmp++;
    if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
    n_cmp++;
    if ({bus.mem_address, bus.mem_w} !== 44'h0) begin
      n_bad++; $display("FAIL reset_addr_w got=%h/%h exp=0/0", bus.mem_address, bus.mem_w);
    end
    n_cmp++;
    if ({bus.mem_wf, bus.mem_mask} !== 33'h0) begin
      n_bad++; $display("FAIL reset_wf_mask got=%b/%h exp=0/0", bus.mem_wf, bus.mem_mask);
    end
    $display("txn reset done");
  endtask

  task automatic test_store_load;
    logic [32:0] got, exp;
    int lat;
    exp_q.push_back({1'b0, 32'h0});
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, got, lat);
    exp = exp_q.pop_front();
    $display("txn st_word addr=010 resp=%h lat=%0d", got, lat);
    n_cmp++;
    if (got !== exp || lat != 1) begin n_bad++; $display("FAIL st_word got=%h lat=%0d exp=%h lat=1", got, lat, exp); end
    n_cmp++;
    if ({acc_wf, acc_mask, acc_addr} !== {1'b1, 32'hFFFFFFFF, 12'h010}) begin
      n_bad++; $display("FAIL st_word_port got=%b/%h/%h exp=1/ffffffff/010", acc_wf, acc_mask, acc_addr);
    end
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, got, lat);
    exp = exp_q.pop_front();
    $display("txn ld_word addr=010 resp=%h lat=%0d", got, lat);
    n_cmp++;
    if (got !== exp || lat != 1) begin n_bad++; $display("FAIL ld_word got=%h lat=%0d exp=%h lat=1", got, lat, exp); end
    n_cmp++;
    if ({acc_wf, acc_mask} !== 33'h0) begin n_bad++; $display("FAIL ld_no_write got=%b/%h exp=0/0", acc_wf, acc_mask); end
  endtask

  task automatic test_byte_half;
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [11:0] ad  [4] = '{12'h010, 12'h013, 12'h011, 12'h012};
    logic [31:0] ev  [4] = '{32'hFFFFFFDE, 32'h000000EF, 32'hFFFFADBE, 32'h0000BEEF};
    logic [32:0] got, exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, ev[i]});
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, got, lat);
      exp = exp_q.pop_front();
      $display("txn ld size=%0d uns=%0d addr=%h resp=%h", sz[i], un[i], ad[i], got);
      n_cmp++;
      if (got !== exp || lat != 1) begin n_bad++; $display("FAIL ld_ext_%0d got=%h lat=%0d exp=%h", i, got, lat, exp); end
    end
  endtask

  task automatic test_store_byte_mask;
    logic [32:0] got, exp;
    int lat;
    exp_q.push_back({1'b0, 32'h0});
    do_req(1'b1, 2'b00, 1'b0, 12'h012, 32'hFFFFFF55, got, lat);
    exp = exp_q.pop_front();
    $display("txn st_byte addr=012 resp=%h mask=%h", got, acc_mask);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL st_byte got=%h exp=%h", got, exp); end
    n_cmp++;
    if ({acc_wf, acc_mask} !== {1'b1, 32'hFF000000}) begin
      n_bad++; $display("FAIL st_byte_mask got=%b/%h exp=1/ff000000", acc_wf, acc_mask);
    end
    exp_q.push_back({1'b0, 32'hDEAD55EF});
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, got, lat);
    exp = exp_q.pop_front();
    $display("txn ld_word addr=010 resp=%h", got);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL ld_after_byte got=%h exp=%h", got, exp); end
  endtask

  task automatic test_boundary;
    logic        we  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz  [8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    logic        un  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] ad  [8] = '{12'd4093, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4092, 12'h040, 12'd4095};
    logic [32:0] ev  [8] = '{{1'b1, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h000000A7}, {1'b0, 32'hFFFFFFA7},
                             {1'b1, 32'h0}, {1'b0, 32'h000000A7}, {1'b1, 32'h0}, {1'b1, 32'h0}};
    logic [32:0] got, exp;
    int lat, wf0, dwf;
    for (int i = 0; i < 8; i++) begin
      wf0 = wf_count;
      exp_q.push_back(ev[i]);
      do_req(we[i], sz[i], un[i], ad[i], 32'h123456A7, got, lat);
      exp = exp_q.pop_front();
      dwf = wf_count - wf0;
      $display("txn bnd we=%0d size=%0d addr=%0d resp=%h writes=%0d", we[i], sz[i], ad[i], got, dwf);
      n_cmp++;
      if (got !== exp || lat != 1) begin n_bad++; $display("FAIL bnd_%0d got=%h lat=%0d exp=%h", i, got, lat, exp); end
      n_cmp++;
      if (dwf != ((we[i] && !exp[32]) ? 1 : 0)) begin
        n_bad++; $display("FAIL bnd_wf_%0d got=%0d exp=%0d", i, dwf, (we[i] && !exp[32]) ? 1 : 0);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [32:0] got, exp;
    int lat, wf0;
    wf0 = wf_count;
    exp_q.push_back({1'b0, 32'hDEAD55EF});
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 12'h010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    // A store to the same word presented while the response is stalled must be ignored.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      $display("txn stall cyc=%0d valid=%0d ready=%0d rdata=%h", i, bus.resp_valid, bus.req_ready, bus.resp_rdata);
      n_cmp++;
      if ({bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata} !== {2'b10, exp}) begin
        n_bad++; $display("FAIL stall_%0d got=%b%b/%h exp=10/%h", i, bus.resp_valid, bus.req_ready,
                          {bus.resp_err, bus.resp_rdata}, exp);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01 || wf_count != wf0) begin
      n_bad++; $display("FAIL stall_release got=%b%b writes=%0d exp=01 writes=%0d", bus.resp_valid, bus.req_ready, wf_count, wf0);
    end
    exp_q.push_back({1'b0, 32'hDEAD55EF});
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, got, lat);
    exp = exp_q.pop_front();
    $display("txn ld_word after stall resp=%h", got);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL stall_ignored got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_write;
    logic [32:0] got, exp;
    int lat, wf0;
    wf0 = wf_count;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 12'h020;
    bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_wf !== 1'b0) begin n_bad++; $display("FAIL rst_write_wf got=%b exp=0", bus.mem_wf); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn rst_in_write valid=%0d ready=%0d writes=%0d", bus.resp_valid, bus.req_ready, wf_count - wf0);
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01 || wf_count != wf0) begin
      n_bad++; $display("FAIL rst_write_state got=%b%b writes=%0d exp=01 writes=%0d", bus.resp_valid, bus.req_ready, wf_count, wf0);
    end
    exp_q.push_back({1'b0, 32'h0});
    do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, got, lat);
    exp = exp_q.pop_front();
    $display("txn ld_word addr=020 resp=%h", got);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL rst_write_mem got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_resp;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b11; bus.req_addr = 12'h030;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_err} !== 2'b11) begin
      n_bad++; $display("FAIL rst_resp_pre got=%b%b exp=11", bus.resp_valid, bus.resp_err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn rst_in_resp valid=%0d err=%0d", bus.resp_valid, bus.resp_err);
    n_cmp++;
    if ({bus.resp_valid, bus.resp_err, bus.req_ready} !== 3'b001) begin
      n_bad++; $display("FAIL rst_resp got=%b%b%b exp=001", bus.resp_valid, bus.resp_err, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic        we, uns;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [32:0] got, exp;
    int lat, prev_acc;
    prev_acc = 0;
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = 12'h100 + 12'($urandom_range(0, 60));
      wd   = $urandom;
      if (size == 2'b11) exp_q.push_back({1'b1, 32'h0});
      else if (we) begin
        case (size)
          2'b00: ref_mem[addr] = wd[7:0];
          2'b01: begin ref_mem[addr] = wd[15:8]; ref_mem[addr + 12'd1] = wd[7:0]; end
          default: begin
            ref_mem[addr] = wd[31:24];          ref_mem[addr + 12'd1] = wd[23:16];
            ref_mem[addr + 12'd2] = wd[15:8];   ref_mem[addr + 12'd3] = wd[7:0];
          end
        endcase
        exp_q.push_back({1'b0, 32'h0});
      end else exp_q.push_back({1'b0, model_load(size, uns, addr)});
      do_req(we, size, uns, addr, wd, got, lat);
      exp = exp_q.pop_front();
      $display("txn b2b %0d we=%0d size=%0d uns=%0d addr=%h resp=%h", i, we, size, uns, addr, got);
      n_cmp++;
      if (got !== exp || lat != 1) begin n_bad++; $display("FAIL b2b_%0d got=%h lat=%0d exp=%h lat=1", i, got, lat, exp); end
      if (i > 0) begin
        n_cmp++;
        if (acc_cyc - prev_acc != 3) begin n_bad++; $display("FAIL b2b_interval_%0d got=%0d exp=3", i, acc_cyc - prev_acc); end
      end
      prev_acc = acc_cyc;
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_half;
    test_store_byte_mask;
    test_boundary;
    test_backpressure;
    test_reset_write;
    test_reset_resp;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
